gf_poly_div_seq: RTL and testbench

Sequential, parametrised GF(2^4) polynomial divider: accepts dividend and divisor polynomials over a valid/ready handshake, runs one long-division step per clock, and returns quotient, remainder and a divide-by-zero flag. Successor to the combinational quotient-only divider. Adds remainder output, backpressure, a selectable coefficient encoding (exponent or integer form) and a fixed, width-parametrised latency so it can sit between registered stages in the decoder datapath.

---
 rtl/gf16_pkg.sv | 46 ++++
 rtl/gf16_vec_conv.sv | 30 +++
 rtl/gf_poly_div_seq.sv | 157 +++++++++++++++
 tb/tb_gf_poly_div_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gf16_pkg.sv
// gf16_pkg: shared GF(2^4) definitions for the polynomial divider.
//   Field generated by x^4 + x + 1 (alpha^4 = 4'd3).
//   GF_ZERO_EXP      : exponent-form code for the zero element.
//   GF_EXP2INT       : alpha^e -> polynomial-basis integer (entry 15 = zero).
//   GF_INT2EXP       : integer -> exponent (entry 0 = GF_ZERO_EXP).
//   gf_mul / gf_inv  : multiply and invert integer-form elements.
//   gf_div_state_t   : divider FSM states.
package gf16_pkg;

  localparam logic [3:0] GF_ZERO_EXP = 4'hF;

  localparam logic [3:0] GF_EXP2INT [16] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
    4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h0
  };

  localparam logic [3:0] GF_INT2EXP [16] = '{
    GF_ZERO_EXP, 4'h0, 4'h1, 4'h4, 4'h2, 4'h8, 4'h5, 4'hA,
    4'h3,        4'hE, 4'h9, 4'h7, 4'h6, 4'hD, 4'hB, 4'hC
  };

  // Multiply through the log domain; exponents add mod 15.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    if (a == 4'h0 || b == 4'h0) return 4'h0;
    s = {1'b0, GF_INT2EXP[a]} + {1'b0, GF_INT2EXP[b]};
    if (s >= 5'd15) s = s - 5'd15;
    return GF_EXP2INT[s[3:0]];
  endfunction

  // alpha^-e = alpha^(15-e); alpha^0 is its own inverse. Zero maps to zero.
  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    logic [3:0] e;
    if (a == 4'h0) return 4'h0;
    e = GF_INT2EXP[a];
    return (e == 4'h0) ? 4'h1 : GF_EXP2INT[4'hF - e];
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_DIV,
    ST_DONE
  } gf_div_state_t;

endpackage

// File: rtl/gf16_vec_conv.sv
// gf16_vec_conv: per-nibble conversion of an IP_WIDTH-coefficient vector
// between exponent form and integer (polynomial-basis) form.
//   i_vec     : input coefficients, nibble k = coefficient of x^k
//   i_convert : 1 = convert, 0 = pass through unchanged
//   i_to_int  : 1 = exponent -> integer, 0 = integer -> exponent
//   o_vec     : converted coefficients
module gf16_vec_conv
  import gf16_pkg::*;
#(
  parameter int IP_WIDTH = 7
) (
  input  logic [IP_WIDTH*4-1:0] i_vec,
  input  logic                  i_convert,
  input  logic                  i_to_int,
  output logic [IP_WIDTH*4-1:0] o_vec
);

  always_comb begin
    // NOTE: o_vec is given a full default before any conditional update, so
    // every path assigns it and no latch is inferred.
    o_vec = i_vec;
    if (i_convert) begin
      for (int k = 0; k < IP_WIDTH; k++) begin
        o_vec[k*4 +: 4] = i_to_int ? GF_EXP2INT[i_vec[k*4 +: 4]]
                                   : GF_INT2EXP[i_vec[k*4 +: 4]];
      end
    end
  end

endmodule

// File: rtl/gf_poly_div_seq.sv
// gf_poly_div_seq: sequential GF(2^4) polynomial long divider.
// One division step per clock; fixed latency of IP_WIDTH+1 edges from accept
// to out_valid, independent of operand values (including divide-by-zero).
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : operand handshake (ready only in IDLE)
//   in_mode         : 0 = exponent form (4'hF is zero), 1 = integer form
//   in_dividend     : dividend coefficients, nibble k = coeff of x^k
//   in_divisor      : divisor coefficients
//   out_valid/ready : result handshake, result held until accepted
//   out_quotient    : quotient in the captured encoding
//   out_remainder   : remainder in the captured encoding
//   out_div0        : divisor was the zero polynomial
module gf_poly_div_seq
  import gf16_pkg::*;
#(
  parameter int IP_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [IP_WIDTH*4-1:0] in_dividend,
  input  logic [IP_WIDTH*4-1:0] in_divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IP_WIDTH*4-1:0] out_quotient,
  output logic [IP_WIDTH*4-1:0] out_remainder,
  output logic                  out_div0
);

  localparam int VW = IP_WIDTH * 4;
  localparam int JW = (IP_WIDTH > 1) ? $clog2(IP_WIDTH) : 1;

  gf_div_state_t r_state;
  logic [VW-1:0] r_rem, r_quo, r_dsr;
  logic          r_mode, r_div0;
  logic [JW-1:0] r_j, r_db;
  logic [3:0]    r_inv;
  logic          r_out_valid, r_out_div0;
  logic [VW-1:0] r_out_q, r_out_r;

  logic [VW-1:0] w_dvd_int, w_dsr_int;
  logic [VW-1:0] w_rem_next, w_quo_next, w_cd;
  logic [VW-1:0] w_q_out, w_r_out;
  logic [JW-1:0] w_db, w_shift;
  logic          w_dsr_zero, w_step;
  logic [3:0]    w_lead, w_coef, w_inv;

  // Capture side: bring operands into integer form for the datapath.
  gf16_vec_conv #(.IP_WIDTH(IP_WIDTH)) u_conv_dvd (
    .i_vec(in_dividend), .i_convert(!in_mode), .i_to_int(1'b1), .o_vec(w_dvd_int)
  );
  gf16_vec_conv #(.IP_WIDTH(IP_WIDTH)) u_conv_dsr (
    .i_vec(in_divisor), .i_convert(!in_mode), .i_to_int(1'b1), .o_vec(w_dsr_int)
  );

  // Output side: converts the final step's results so they can be registered
  // on the same edge that completes the division.
  gf16_vec_conv #(.IP_WIDTH(IP_WIDTH)) u_conv_quo (
    .i_vec(w_quo_next), .i_convert(!r_mode), .i_to_int(1'b0), .o_vec(w_q_out)
  );
  gf16_vec_conv #(.IP_WIDTH(IP_WIDTH)) u_conv_rem (
    .i_vec(w_rem_next), .i_convert(!r_mode), .i_to_int(1'b0), .o_vec(w_r_out)
  );

  // Divisor degree: ascending scan, so the highest nonzero nibble wins.
  always_comb begin
    w_db       = '0;
    w_dsr_zero = 1'b1;
    for (int k = 0; k < IP_WIDTH; k++) begin
      if (r_dsr[k*4 +: 4] != 4'h0) begin
        w_db       = JW'(k);
        w_dsr_zero = 1'b0;
      end
    end
    w_inv = gf_inv(r_dsr[int'(w_db)*4 +: 4]);
  end

  // One long-division step: cancel r[j] using c*d aligned to position j.
  always_comb begin
    w_shift    = r_j - r_db;
    w_lead     = r_rem[int'(r_j)*4 +: 4];
    w_step     = (r_j >= r_db) && (w_lead != 4'h0) && !r_div0;
    w_coef     = gf_mul(w_lead, r_inv);
    for (int k = 0; k < IP_WIDTH; k++) begin
      w_cd[k*4 +: 4] = gf_mul(w_coef, r_dsr[k*4 +: 4]);
    end
    w_rem_next = r_rem;
    w_quo_next = r_quo;
    if (w_step) begin
      w_rem_next = r_rem ^ (w_cd << (4 * int'(w_shift)));
      w_quo_next[int'(w_shift)*4 +: 4] = w_coef;
    end
  end

  // NOTE: only control state and the visible outputs are reset; the operand
  // and working registers are always reloaded before use, so leaving them
  // unreset keeps the reset net off the wide datapath.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_q     <= '0;
      r_out_r     <= '0;
      r_out_div0  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_rem   <= w_dvd_int;
            r_dsr   <= w_dsr_int;
            r_mode  <= in_mode;
            r_state <= ST_NORM;
          end
        end
        ST_NORM: begin
          r_db    <= w_db;
          r_inv   <= w_inv;
          r_div0  <= w_dsr_zero;
          r_quo   <= '0;
          r_j     <= JW'(IP_WIDTH - 1);
          r_state <= ST_DIV;
        end
        ST_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (r_j == '0) begin
            r_out_q     <= w_q_out;
            r_out_r     <= w_r_out;
            r_out_div0  <= r_div0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_j <= r_j - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = (r_state == ST_IDLE);
  assign out_valid     = r_out_valid;
  assign out_quotient  = r_out_q;
  assign out_remainder = r_out_r;
  assign out_div0      = r_out_div0;

endmodule

// File: tb/tb_gf_poly_div_seq.sv
// Testbench for gf_poly_div_seq (IP_WIDTH = 7): table of division vectors
// with hand-derived results, a scoreboard queue of expected results, plus
// backpressure and mid-division reset sequences.
module tb_gf_poly_div_seq;

  localparam int W   = 7;
  localparam int VW  = W * 4;
  localparam int LAT = W + 1;

  typedef struct {
    logic [VW-1:0] q;
    logic [VW-1:0] r;
    logic          d0;
  } exp_t;

  typedef struct {
    string         name;
    logic          mode;
    logic [VW-1:0] dvd;
    logic [VW-1:0] dsr;
    logic [VW-1:0] q;
    logic [VW-1:0] r;
    logic          d0;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_mode;
  logic [VW-1:0] in_dividend, in_divisor;
  logic          out_valid, out_ready, out_div0;
  logic [VW-1:0] out_quotient, out_remainder;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  gf_poly_div_seq #(.IP_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_div0(out_div0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Present one operand pair at the accepting edge and record its expectation.
  task automatic drive(input logic mode, input logic [VW-1:0] dvd,
                       input logic [VW-1:0] dsr, input exp_t e);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_mode     = mode;
    in_dividend = dvd;
    in_divisor  = dsr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_mode     = ~mode;
    in_dividend = VW'($urandom);
    in_divisor  = VW'($urandom);
  endtask

  // Count edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic compare_result(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_scoreboard_nonempty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({name, "_valid"},     32'(out_valid),     32'd1);
    check({name, "_quotient"},  32'(out_quotient),  32'(e.q));
    check({name, "_remainder"}, 32'(out_remainder), 32'(e.r));
    check({name, "_div0"},      32'(out_div0),      32'(e.d0));
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   lat;
    e = '{q: v.q, r: v.r, d0: v.d0};
    drive(v.mode, v.dvd, v.dsr, e);
    wait_result(lat);
    check({v.name, "_latency"}, 32'(lat), 32'(LAT));
    compare_result(v.name);
    @(posedge clk);
    #1;
    check({v.name, "_handoff_ready"}, 32'(in_ready),  32'd1);
    check({v.name, "_handoff_valid"}, 32'(out_valid), 32'd0);
  endtask

  // Watch for a result that should never appear (ignored or aborted job).
  task automatic expect_idle(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int lat;

    vecs[0] = '{"exp_basic",   1'b0, 28'hFFFF000, 28'hFFFFF00, 28'hFFFFF0F, 28'hFFFFFF0, 1'b0};
    vecs[1] = '{"exp_wrap",    1'b0, 28'hFFFFFF1, 28'hFFFFFF3, 28'hFFFFFFD, 28'hFFFFFFF, 1'b0};
    vecs[2] = '{"exp_div0",    1'b0, 28'hFFF12F3, 28'hFFFFFFF, 28'hFFFFFFF, 28'hFFF12F3, 1'b1};
    vecs[3] = '{"int_basic",   1'b1, 28'h0000100, 28'h0000010, 28'h0000010, 28'h0000000, 1'b0};
    vecs[4] = '{"int_lowdeg",  1'b1, 28'h0000005, 28'h0000100, 28'h0000000, 28'h0000005, 1'b0};
    vecs[5] = '{"int_msb_dsr", 1'b1, 28'h7000000, 28'h1000000, 28'h0000007, 28'h0000000, 1'b0};
    vecs[6] = '{"int_rem",     1'b1, 28'h0000103, 28'h0000012, 28'h0000012, 28'h0000007, 1'b0};
    vecs[7] = '{"int_div0",    1'b1, 28'h0000ABC, 28'h0000000, 28'h0000000, 28'h0000ABC, 1'b1};
    vecs[8] = '{"int_nonmonic",1'b1, 28'h0000030, 28'h0000002, 28'h0000080, 28'h0000000, 1'b0};
    vecs[9] = '{"exp_zero_dvd",1'b0, 28'hFFFFFFF, 28'hFFFFFF0, 28'hFFFFFFF, 28'hFFFFFFF, 1'b0};

    // Reset with in_valid high: it must not start a job.
    rst         = 1'b1;
    in_valid    = 1'b1;
    in_mode     = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid),     32'd0);
    check("reset_in_ready",  32'(in_ready),      32'd1);
    check("reset_quotient",  32'(out_quotient),  32'd0);
    check("reset_remainder", 32'(out_remainder), 32'd0);
    check("reset_div0",      32'(out_div0),      32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure: result held for 5 cycles, in_valid pulse ignored.
    out_ready = 1'b0;
    drive(vecs[0].mode, vecs[0].dvd, vecs[0].dsr,
          '{q: vecs[0].q, r: vecs[0].r, d0: vecs[0].d0});
    wait_result(lat);
    check("bp_latency", 32'(lat), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid    = (i == 2);
      in_mode     = 1'b1;
      in_dividend = vecs[3].dvd;
      in_divisor  = vecs[3].dsr;
      @(posedge clk);
      #1;
      check("bp_hold_valid",     32'(out_valid),     32'd1);
      check("bp_hold_ready",     32'(in_ready),      32'd0);
      check("bp_hold_quotient",  32'(out_quotient),  32'(vecs[0].q));
      check("bp_hold_remainder", 32'(out_remainder), 32'(vecs[0].r));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    compare_result("bp");
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready),  32'd1);
    expect_idle("bp_no_ghost_job", 12);

    // Reset in the middle of DIV (after edge 4), with in_valid asserted.
    drive(vecs[1].mode, vecs[1].dvd, vecs[1].dsr,
          '{q: vecs[1].q, r: vecs[1].r, d0: vecs[1].d0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("middiv_busy", 32'(in_ready), 32'd0);
    rst         = 1'b1;
    in_valid    = 1'b1;
    in_dividend = vecs[3].dvd;
    in_divisor  = vecs[3].dsr;
    @(posedge clk);
    #1;
    sb.delete();
    check("middiv_rst_valid",     32'(out_valid),     32'd0);
    check("middiv_rst_ready",     32'(in_ready),      32'd1);
    check("middiv_rst_quotient",  32'(out_quotient),  32'd0);
    check("middiv_rst_remainder", 32'(out_remainder), 32'd0);
    check("middiv_rst_div0",      32'(out_div0),      32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    expect_idle("middiv_job_discarded", 12);
    run_vec(vecs[6]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
